// File: rtl/conv_window_feeder.sv
// Builds 3x3 raster windows from an 8-bit pixel stream and presents them with held weights/bias to the MAC.
// Latency: win_valid/image/frame_done one cycle after the accept that completes a window.
// Backpressure: pix_ready low only while waiting for weights; SOF-less pixels in READY are dropped.
module conv_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int COL_W = 3,
    parameter int ROW_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic [35:0] wgt_in,
    input  logic [4:0]  bias_in,
    input  logic        wgt_load,
    output logic [71:0] image,
    output logic [35:0] weight,
    output logic [4:0]  exp_bias,
    output logic        win_valid,
    output logic        frame_done,
    output logic        wgt_err,
    output logic        sof_err
);

    typedef enum logic [1:0] {
        WAIT_WGT = 2'd0,
        READY    = 2'd1,
        STREAM   = 2'd2
    } state_t;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    // Line buffers: lb1 holds the previous row, lb0 the row before that.
    logic [7:0]       r_lb0 [IMG_W];
    logic [7:0]       r_lb1 [IMG_W];

    // The two most recent columns; the third (rightmost) column is the one arriving now.
    logic [23:0]      r_wc0;
    logic [23:0]      r_wc1;

    logic             w_accept;
    logic             w_wgt_we;
    logic             w_wgt_err;
    logic             w_sof_err;
    logic             w_last;
    logic             w_win;
    logic [COL_W-1:0] w_col;
    logic [ROW_W-1:0] w_row;
    logic [7:0]       w_lb0_rd;
    logic [7:0]       w_lb1_rd;
    logic [23:0]      w_new_col;

    // A SOF pixel is always element (0,0), whatever the counters say.
    assign w_col     = pix_sof ? '0 : r_col;
    assign w_row     = pix_sof ? '0 : r_row;
    assign w_last    = (w_row == ROW_LAST) && (w_col == COL_LAST);
    assign w_win     = w_accept && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
    assign w_lb0_rd  = r_lb0[w_col];
    assign w_lb1_rd  = r_lb1[w_col];
    assign w_new_col = {w_lb0_rd, w_lb1_rd, pix_in};
    assign pix_ready = (r_state != WAIT_WGT);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= WAIT_WGT;
        else      r_state <= w_state_nxt;
    end

    // Next state, accept qualification and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_wgt_we    = 1'b0;
        w_wgt_err   = 1'b0;
        w_sof_err   = 1'b0;
        case (r_state)
            WAIT_WGT: begin
                if (wgt_load) begin
                    w_wgt_we    = 1'b1;
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_wgt_we = wgt_load;
                if (pix_valid) begin
                    if (pix_sof) begin
                        w_accept    = 1'b1;
                        w_state_nxt = STREAM;
                    end else begin
                        w_sof_err   = 1'b1;
                    end
                end
            end
            STREAM: begin
                w_wgt_err = wgt_load;
                if (pix_valid) begin
                    w_accept  = 1'b1;
                    w_sof_err = pix_sof;
                end
            end
            default: w_state_nxt = WAIT_WGT;
        endcase
        if (w_accept && w_last) w_state_nxt = READY;
    end

    // Row/column position of the next expected pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_col == COL_LAST) begin
                r_col <= '0;
                r_row <= w_row + ROW_W'(1);
            end else begin
                r_col <= w_col + COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    // Line buffer update; contents need no reset as every entry is rewritten before it feeds a window.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[w_col] <= w_lb1_rd;
            r_lb1[w_col] <= pix_in;
        end
    end

    // Shift window columns left on each accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wc0 <= '0;
            r_wc1 <= '0;
        end else if (w_accept) begin
            r_wc0 <= r_wc1;
            r_wc1 <= w_new_col;
        end
    end

    // Publish a complete window in raster order; image holds between windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image      <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= w_win;
            frame_done <= w_accept && w_last;
            if (w_win) begin
                image <= {r_wc0[23:16], r_wc1[23:16], w_new_col[23:16],
                          r_wc0[15:8],  r_wc1[15:8],  w_new_col[15:8],
                          r_wc0[7:0],   r_wc1[7:0],   w_new_col[7:0]};
            end
        end
    end

    // Weight/bias holding registers and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            weight   <= '0;
            exp_bias <= '0;
            wgt_err  <= 1'b0;
            sof_err  <= 1'b0;
        end else begin
            wgt_err <= w_wgt_err;
            sof_err <= w_sof_err;
            if (w_wgt_we) begin
                weight   <= wgt_in;
                exp_bias <= bias_in;
            end
        end
    end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Streaming front end that sits directly upstream of the 9-way MAC.
- Accepts a raster-ordered stream of 8-bit image elements and builds 3x3 windows using two line buffers and a 3x3 shift window.
- Drives the MAC's `image[71:0]`, `weight[35:0]` and `exp_bias[4:0]` inputs, with a `win_valid` qualifier marking each cycle that carries a complete window.
- Supports valid (unpadded) convolution only; weights and bias are loaded between frames and held stable for the whole frame.

Parameters:
- `IMG_W`, default 8: frame width in elements; must be ≥ 3.
- `IMG_H`, default 8: frame height in rows; must be ≥ 3.
- `COL_W`, default 3: column counter width, equal to clog2(`IMG_W`).
- `ROW_W`, default 3: row counter width, equal to clog2(`IMG_H`).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `pix_in` input 8: image element.
- `pix_valid` input 1: `pix_in` is valid.
- `pix_sof` input 1: start of frame, qualified by `pix_valid`.
- `pix_ready` output 1: block can accept a pixel.
- `wgt_in` input 36: 3x3 weights, 4 bits each; `[35:32]` pairs with the top-left element.
- `bias_in` input 5: exponent bias.
- `wgt_load` input 1: load strobe for `wgt_in` and `bias_in`.
- `image` output 72: window; `[71:64]` is top-left, raster order; `[7:0]` is bottom-right.
- `weight` output 36: held weights.
- `exp_bias` output 5: held bias.
- `win_valid` output 1: `image` holds a complete window this cycle.
- `frame_done` output 1: one-cycle pulse with the last window of a frame.
- `wgt_err` output 1: one-cycle pulse when `wgt_load` is rejected.
- `sof_err` output 1: one-cycle pulse on an unexpected `pix_sof`.

Behaviour:
- Reset (`rst`=0, async):
  - State goes to WAIT_WGT.
  - All outputs go to 0: `image`, `weight`, `exp_bias`, `win_valid`, `frame_done`, `wgt_err`, `sof_err`, `pix_ready`.
  - Row and column counters go to 0.
  - Line buffer contents are not reset. They are never observed before being rewritten.
- States:
  - WAIT_WGT: `pix_ready`=0; `wgt_load` loads the weight and bias registers and moves to READY.
  - READY: `pix_ready`=1; `wgt_load` reloads the registers. A `pix_valid` with `pix_sof`=1 is accepted as element (0,0) and moves to STREAM. A `pix_valid` with `pix_sof`=0 is dropped (not accepted) and pulses `sof_err`.
  - STREAM: `pix_ready`=1; each `pix_valid` is accepted. `wgt_load` is ignored and pulses `wgt_err`; `weight` and `exp_bias` stay unchanged.
- A pixel is accepted on a cycle with `pix_valid` & `pix_ready`.
- Counters on each accept:
  - `col` increments; at `IMG_W`-1 it wraps to 0 and `row` increments.
  - The accept at (`IMG_H`-1, `IMG_W`-1) returns the state to READY and clears both counters.
- Line buffers: `lb1` holds row r-1 and `lb0` holds row r-2, both indexed by `col`. On an accept at column c:
  - read `lb0[c]` and `lb1[c]`;
  - write `lb0[c]` <= `lb1[c]`, then `lb1[c]` <= `pix_in`.
- Window:
  - Three 3-element column registers shift left on each accept.
  - The new column is {`lb0[c]`, `lb1[c]`, `pix_in`}, ordered top to bottom.
  - The window is not updated on cycles without an accept.
- `win_valid`:
  - Registered; asserts in the cycle after an accept at `row`≥2 and `col`≥2. Latency is 1 cycle from accept.
  - `image` changes only with `win_valid`, and holds its last value otherwise.
  - Windows per frame = (`IMG_H`-2)*(`IMG_W`-2).
- `frame_done` asserts together with the `win_valid` of the final accept.
- Gaps in `pix_valid` stall counters and window; no data is lost and no bubbles are inserted.
- `pix_sof`=1 in STREAM:
  - pulses `sof_err`;
  - the pixel is treated as (0,0) of a new frame and the counters restart;
  - no `frame_done` is issued for the aborted frame.
- `wgt_load` and a SOF accept in the same READY cycle: both take effect on that edge.
- Reset mid-frame: the aborted frame produces no further windows; a weight reload is required before new pixels are accepted.

Test Plan:
1. Reset, then `wgt_load` with `wgt_in`=36'h123456789, `bias_in`=5'd15, `IMG_W`=`IMG_H`=4 -> `weight`=36'h123456789, `exp_bias`=15, `pix_ready`=1 from the next cycle.
2. Stream elements 0x01..0x10 contiguously with SOF on 0x01 -> exactly 4 windows, each one cycle after accepting 0x0B, 0x0C, 0x0F, 0x10:
   - first window `image`=72'h010203_050607_090A0B;
   - last window 72'h060708_0A0B0C_0E0F10, with `frame_done`=1.
3. Repeat test 2 with `pix_valid` deasserted every other cycle -> identical window values and count; each `win_valid` one cycle after the corresponding accept.
4. `wgt_load` with 36'hFFFFFFFFF mid-frame -> `wgt_err` pulse; `weight` stays 36'h123456789; windows unaffected.
5. Assert `pix_sof` on the 7th element -> `sof_err` pulse and the counters restart. Feeding 16 more elements yields 4 windows relative to the new start; the first uses the new rows 0..2.
6. Drop `rst` after the 10th element, then release and reload -> outputs are 0 during reset; no window appears until 11 elements of a new frame have been accepted.
